// File: rtl/alu_result_stage.sv
// -----------------------------------------------------------------------------
// alu_result_stage
//   Result-selection and output buffering stage of an ALU. On each accepted
//   operation the result of the single enabled unit (Arith/Logic/CMP/SHIFT) is
//   captured. A zero or multi-hot select captures 0 and flags SEL_ERR. A
//   two-entry buffer (output register + skid register) decouples upstream from
//   downstream back-pressure while keeping IN_READY a pure flop output.
//
// Ports
//   CLK, RST                 clock (rising edge), async active-low reset
//   Arith/Logic/CMP/SHIFT_Enable   unit-select enables
//   Arith/Logic/CMP/SHIFT_OUT      signed unit results, OUT_WIDTH bits each
//   IN_VALID / IN_READY      upstream handshake
//   ALU_OUT, UNIT_TAG, SEL_ERR     registered result, its enables, select error
//   OUT_VALID / OUT_READY    downstream handshake
//   ERR_CNT                  saturating count of accepted illegal selects
// -----------------------------------------------------------------------------
module alu_result_stage #(
  parameter int OUT_WIDTH = 16
) (
  input  logic                 CLK,
  input  logic                 RST,
  input  logic                 Arith_Enable,
  input  logic                 Logic_Enable,
  input  logic                 CMP_Enable,
  input  logic                 SHIFT_Enable,
  input  logic [OUT_WIDTH-1:0] Arith_OUT,
  input  logic [OUT_WIDTH-1:0] Logic_OUT,
  input  logic [OUT_WIDTH-1:0] CMP_OUT,
  input  logic [OUT_WIDTH-1:0] SHIFT_OUT,
  input  logic                 IN_VALID,
  output logic                 IN_READY,
  output logic [OUT_WIDTH-1:0] ALU_OUT,
  output logic [3:0]           UNIT_TAG,
  output logic                 OUT_VALID,
  input  logic                 OUT_READY,
  output logic                 SEL_ERR,
  output logic [7:0]           ERR_CNT
);

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_ONE   = 2'd1,
    ST_FULL  = 2'd2
  } state_t;

  // True when exactly one of the four enables is set.
  function automatic logic f_is_onehot(input logic [3:0] en);
    logic v;
    case (en)
      4'b1000, 4'b0100, 4'b0010, 4'b0001: v = 1'b1;
      default:                            v = 1'b0;
    endcase
    return v;
  endfunction

  // Picks the enabled unit's result; any non-one-hot select yields zero.
  function automatic logic [OUT_WIDTH-1:0] f_select(
    input logic [3:0]           en,
    input logic [OUT_WIDTH-1:0] a,
    input logic [OUT_WIDTH-1:0] l,
    input logic [OUT_WIDTH-1:0] c,
    input logic [OUT_WIDTH-1:0] s
  );
    logic [OUT_WIDTH-1:0] v;
    case (en)
      4'b1000: v = a;
      4'b0100: v = l;
      4'b0010: v = c;
      4'b0001: v = s;
      default: v = {OUT_WIDTH{1'b0}};
    endcase
    return v;
  endfunction

  state_t               r_state;
  logic [OUT_WIDTH-1:0] r_oreg_data;
  logic [3:0]           r_oreg_tag;
  logic                 r_oreg_err;
  logic                 r_oreg_valid;
  logic [OUT_WIDTH-1:0] r_sreg_data;
  logic [3:0]           r_sreg_tag;
  logic                 r_sreg_err;
  logic                 r_sreg_valid;
  logic                 r_in_ready;
  logic [7:0]           r_err_cnt;

  state_t               w_state_nxt;
  logic [OUT_WIDTH-1:0] w_oreg_data_nxt;
  logic [3:0]           w_oreg_tag_nxt;
  logic                 w_oreg_err_nxt;
  logic [OUT_WIDTH-1:0] w_sreg_data_nxt;
  logic [3:0]           w_sreg_tag_nxt;
  logic                 w_sreg_err_nxt;
  logic [7:0]           w_err_cnt_nxt;

  logic                 w_accept;
  logic                 w_drain;
  logic [3:0]           w_new_tag;
  logic                 w_new_err;
  logic [OUT_WIDTH-1:0] w_new_data;

  assign w_accept   = IN_VALID & r_in_ready;
  assign w_drain    = r_oreg_valid & OUT_READY;
  assign w_new_tag  = {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable};
  assign w_new_err  = ~f_is_onehot(w_new_tag);
  assign w_new_data = f_select(w_new_tag, Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT);

  // Occupancy next-state and entry loading for OREG/SREG.
  always_comb begin
    w_state_nxt     = r_state;
    w_oreg_data_nxt = r_oreg_data;
    w_oreg_tag_nxt  = r_oreg_tag;
    w_oreg_err_nxt  = r_oreg_err;
    w_sreg_data_nxt = r_sreg_data;
    w_sreg_tag_nxt  = r_sreg_tag;
    w_sreg_err_nxt  = r_sreg_err;
    case (r_state)
      ST_EMPTY: begin
        if (w_accept) begin
          w_state_nxt     = ST_ONE;
          w_oreg_data_nxt = w_new_data;
          w_oreg_tag_nxt  = w_new_tag;
          w_oreg_err_nxt  = w_new_err;
        end else begin
          w_state_nxt = ST_EMPTY;
        end
      end
      ST_ONE: begin
        if (w_drain && w_accept) begin
          w_state_nxt     = ST_ONE;
          w_oreg_data_nxt = w_new_data;
          w_oreg_tag_nxt  = w_new_tag;
          w_oreg_err_nxt  = w_new_err;
        end else if (w_drain) begin
          // ALU_OUT keeps its last value once the buffer empties.
          w_state_nxt = ST_EMPTY;
        end else if (w_accept) begin
          w_state_nxt     = ST_FULL;
          w_sreg_data_nxt = w_new_data;
          w_sreg_tag_nxt  = w_new_tag;
          w_sreg_err_nxt  = w_new_err;
        end else begin
          w_state_nxt = ST_ONE;
        end
      end
      ST_FULL: begin
        // IN_READY is low here, so only a drain can change occupancy.
        if (w_drain) begin
          w_state_nxt     = ST_ONE;
          w_oreg_data_nxt = r_sreg_data;
          w_oreg_tag_nxt  = r_sreg_tag;
          w_oreg_err_nxt  = r_sreg_err;
        end else begin
          w_state_nxt = ST_FULL;
        end
      end
      default: begin
        w_state_nxt = ST_EMPTY;
      end
    endcase
  end

  // Saturating illegal-select counter next value.
  always_comb begin
    w_err_cnt_nxt = r_err_cnt;
    if (w_accept && w_new_err && (r_err_cnt != 8'd255)) begin
      w_err_cnt_nxt = r_err_cnt + 8'd1;
    end else begin
      w_err_cnt_nxt = r_err_cnt;
    end
  end

  // State, entry storage and registered handshake flags.
  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_state      <= ST_EMPTY;
      r_oreg_data  <= {OUT_WIDTH{1'b0}};
      r_oreg_tag   <= 4'b0000;
      r_oreg_err   <= 1'b0;
      r_oreg_valid <= 1'b0;
      r_sreg_data  <= {OUT_WIDTH{1'b0}};
      r_sreg_tag   <= 4'b0000;
      r_sreg_err   <= 1'b0;
      r_sreg_valid <= 1'b0;
      r_in_ready   <= 1'b1;
      r_err_cnt    <= 8'd0;
    end else begin
      r_state      <= w_state_nxt;
      r_oreg_data  <= w_oreg_data_nxt;
      r_oreg_tag   <= w_oreg_tag_nxt;
      r_oreg_err   <= w_oreg_err_nxt;
      r_oreg_valid <= (w_state_nxt != ST_EMPTY);
      r_sreg_data  <= w_sreg_data_nxt;
      r_sreg_tag   <= w_sreg_tag_nxt;
      r_sreg_err   <= w_sreg_err_nxt;
      r_sreg_valid <= (w_state_nxt == ST_FULL);
      // Ready is the registered complement of next-cycle SREG occupancy.
      r_in_ready   <= (w_state_nxt != ST_FULL);
      r_err_cnt    <= w_err_cnt_nxt;
    end
  end

  assign IN_READY  = r_in_ready;
  assign OUT_VALID = r_oreg_valid;
  assign ALU_OUT   = r_oreg_data;
  assign UNIT_TAG  = r_oreg_tag;
  assign SEL_ERR   = r_oreg_err;
  assign ERR_CNT   = r_err_cnt;

endmodule

// File: tb/tb_alu_result_stage.sv
// -----------------------------------------------------------------------------
// tb_alu_result_stage
//   Self-checking bench for alu_result_stage. A queue of expected entries
//   models the stage: its size is the occupancy, its head is what must be on
//   the outputs. Directed scenarios pin the model with literal values, then a
//   long randomized run compares every cycle.
// -----------------------------------------------------------------------------
module tb_alu_result_stage;

  localparam int W = 16;

  logic         CLK;
  logic         RST;
  logic         Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable;
  logic [W-1:0] Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT;
  logic         IN_VALID;
  logic         IN_READY;
  logic [W-1:0] ALU_OUT;
  logic [3:0]   UNIT_TAG;
  logic         OUT_VALID;
  logic         OUT_READY;
  logic         SEL_ERR;
  logic [7:0]   ERR_CNT;

  alu_result_stage #(.OUT_WIDTH(W)) dut (
    .CLK(CLK), .RST(RST),
    .Arith_Enable(Arith_Enable), .Logic_Enable(Logic_Enable),
    .CMP_Enable(CMP_Enable), .SHIFT_Enable(SHIFT_Enable),
    .Arith_OUT(Arith_OUT), .Logic_OUT(Logic_OUT),
    .CMP_OUT(CMP_OUT), .SHIFT_OUT(SHIFT_OUT),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY),
    .ALU_OUT(ALU_OUT), .UNIT_TAG(UNIT_TAG), .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY), .SEL_ERR(SEL_ERR), .ERR_CNT(ERR_CNT)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  typedef struct {
    logic [W-1:0] data;
    logic [3:0]   tag;
    logic         err;
  } entry_t;

  entry_t q[$];
  int     m_err_cnt;
  int     total;
  int     bad;

  // Generic comparison; every check in the bench goes through here.
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Compare all outputs against the queue model.
  task automatic check_model();
    chk("out_valid", 32'(OUT_VALID), 32'(q.size() > 0));
    chk("in_ready", 32'(IN_READY), 32'(q.size() < 2));
    chk("err_cnt", 32'(ERR_CNT), 32'(m_err_cnt));
    if (q.size() > 0) begin
      chk("alu_out", 32'(ALU_OUT), 32'(q[0].data));
      chk("unit_tag", 32'(UNIT_TAG), 32'(q[0].tag));
      chk("sel_err", 32'(SEL_ERR), 32'(q[0].err));
    end
  endtask

  // Apply one edge to the model, then check outputs on the falling edge.
  task automatic cycle();
    entry_t     e;
    logic [3:0] en;
    bit         acc;
    bit         drn;
    @(posedge CLK);
    en  = {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable};
    acc = IN_VALID && (q.size() < 2);
    drn = (q.size() > 0) && OUT_READY;
    if (drn) void'(q.pop_front());
    if (acc) begin
      e.tag = en;
      e.err = ($countones(en) != 1);
      if (e.err)       e.data = '0;
      else if (en[3])  e.data = Arith_OUT;
      else if (en[2])  e.data = Logic_OUT;
      else if (en[1])  e.data = CMP_OUT;
      else             e.data = SHIFT_OUT;
      q.push_back(e);
      if (e.err && m_err_cnt < 255) m_err_cnt++;
    end
    @(negedge CLK);
    check_model();
  endtask

  task automatic set_op(input logic [3:0] en);
    {Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable} = en;
    Arith_OUT = W'($urandom);
    Logic_OUT = W'($urandom);
    CMP_OUT   = W'($urandom);
    SHIFT_OUT = W'($urandom);
  endtask

  function automatic logic [3:0] rand_illegal();
    logic [3:0] en;
    en = 4'($urandom);
    while ($countones(en) == 1) en = 4'($urandom);
    return en;
  endfunction

  initial begin
    total = 0; bad = 0; m_err_cnt = 0;
    RST = 1'b0; IN_VALID = 1'b0; OUT_READY = 1'b0;
    set_op(4'b0000);
    #12;
    // Reset values
    chk("rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("rst_in_ready", 32'(IN_READY), 32'd1);
    chk("rst_alu_out", 32'(ALU_OUT), 32'd0);
    chk("rst_unit_tag", 32'(UNIT_TAG), 32'd0);
    chk("rst_sel_err", 32'(SEL_ERR), 32'd0);
    chk("rst_err_cnt", 32'(ERR_CNT), 32'd0);
    @(negedge CLK);
    RST = 1'b1;

    // Single arithmetic op, -10
    set_op(4'b1000); Arith_OUT = 16'hFFF6; IN_VALID = 1'b1; OUT_READY = 1'b1;
    cycle();
    chk("arith_valid", 32'(OUT_VALID), 32'd1);
    chk("arith_data", 32'(ALU_OUT), 32'h0000FFF6);
    chk("arith_tag", 32'(UNIT_TAG), 32'h8);
    chk("arith_err", 32'(SEL_ERR), 32'd0);
    IN_VALID = 1'b0;
    cycle();

    // Skid: CMP then SHIFT under back-pressure
    OUT_READY = 1'b0;
    set_op(4'b0010); CMP_OUT = 16'h0001; IN_VALID = 1'b1;
    cycle();
    set_op(4'b0001); SHIFT_OUT = 16'h0008;
    cycle();
    chk("skid_in_ready", 32'(IN_READY), 32'd0);
    chk("skid_head", 32'(ALU_OUT), 32'h1);
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    cycle();
    chk("skid_second", 32'(ALU_OUT), 32'h8);
    chk("skid_ready_back", 32'(IN_READY), 32'd1);
    cycle();

    // Illegal selects
    set_op(4'b0000); IN_VALID = 1'b1;
    cycle();
    chk("ill0_data", 32'(ALU_OUT), 32'd0);
    chk("ill0_err", 32'(SEL_ERR), 32'd1);
    chk("ill0_tag", 32'(UNIT_TAG), 32'h0);
    set_op(4'b0110);
    cycle();
    chk("ill1_data", 32'(ALU_OUT), 32'd0);
    chk("ill1_err", 32'(SEL_ERR), 32'd1);
    chk("ill1_tag", 32'(UNIT_TAG), 32'h6);
    chk("ill_cnt", 32'(ERR_CNT), 32'd2);
    IN_VALID = 1'b0;
    cycle();

    // Reset asserted while FULL
    OUT_READY = 1'b0; IN_VALID = 1'b1;
    set_op(4'b0100); cycle();
    set_op(4'b0010); cycle();
    chk("full_in_ready", 32'(IN_READY), 32'd0);
    IN_VALID = 1'b0;
    #2 RST = 1'b0;
    #1;
    chk("mid_rst_out_valid", 32'(OUT_VALID), 32'd0);
    chk("mid_rst_in_ready", 32'(IN_READY), 32'd1);
    chk("mid_rst_err_cnt", 32'(ERR_CNT), 32'd0);
    q.delete(); m_err_cnt = 0;
    @(posedge CLK);
    #1 RST = 1'b1;
    @(negedge CLK);
    check_model();
    OUT_READY = 1'b1;
    cycle();
    chk("post_rst_quiet", 32'(OUT_VALID), 32'd0);
    set_op(4'b0100); Logic_OUT = 16'h00F0; IN_VALID = 1'b1;
    cycle();
    chk("post_rst_data", 32'(ALU_OUT), 32'h00F0);
    chk("post_rst_tag", 32'(UNIT_TAG), 32'h4);
    IN_VALID = 1'b0;
    cycle();

    // Randomized traffic
    for (int i = 0; i < 10000; i++) begin
      if ($urandom_range(0, 9) == 0) set_op(rand_illegal());
      else set_op(4'(4'b0001 << $urandom_range(0, 3)));
      IN_VALID  = ($urandom_range(0, 3) != 0);
      OUT_READY = ($urandom_range(0, 2) != 0);
      cycle();
    end
    IN_VALID = 1'b0; OUT_READY = 1'b1;
    cycle(); cycle();

    // Counter saturation after a fresh reset
    @(negedge CLK);
    RST = 1'b0;
    q.delete(); m_err_cnt = 0;
    @(negedge CLK);
    RST = 1'b1;
    check_model();
    IN_VALID = 1'b1; OUT_READY = 1'b1;
    for (int i = 0; i < 300; i++) begin
      set_op(rand_illegal());
      cycle();
      if (i == 254) chk("sat_reach", 32'(ERR_CNT), 32'd255);
    end
    chk("sat_hold", 32'(ERR_CNT), 32'd255);
    IN_VALID = 1'b0;
    cycle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_stage.md
ALU_RESULT_STAGE -- requirements
Module: alu_result_stage

Interface
REQ-001 Parameter: OUT_WIDTH, 16, width of every unit result and of ALU_OUT.
REQ-002 Port: CLK  input  1  single clock for all state; rising-edge.
REQ-003 Port: RST  input  1  reset, asynchronous assert, active-low.
REQ-004 Port: Arith_Enable, Logic_Enable, CMP_Enable, SHIFT_Enable  input  1 each  unit-select enables from the ALU_FUN decoder.
REQ-005 Port: Arith_OUT, Logic_OUT, CMP_OUT, SHIFT_OUT  input  OUT_WIDTH each  signed unit results, valid in the same cycle as the enables.
REQ-006 Port: IN_VALID  input  1  upstream operation present this cycle.
REQ-007 Port: IN_READY  output  1  stage can accept an operation this cycle.
REQ-008 Port: ALU_OUT  output  OUT_WIDTH  registered selected result.
REQ-009 Port: UNIT_TAG  output  4  registered enables of ALU_OUT's operation, bit order {Arith, Logic, CMP, SHIFT}.
REQ-010 Port: OUT_VALID  output  1  ALU_OUT/UNIT_TAG/SEL_ERR hold a result.
REQ-011 Port: OUT_READY  input  1  downstream accepts the result this cycle.
REQ-012 Port: SEL_ERR  output  1  current result's enables were not one-hot.
REQ-013 Port: ERR_CNT  output  8  count of accepted operations with non-one-hot enables.

Function
REQ-014 Accept: operation is accepted on a rising CLK edge where IN_VALID=1 and IN_READY=1; no other input sampling occurs.
REQ-015 Select: exactly one enable high -> captured result is that unit's OUT; the value is passed unmodified, no sign extension or truncation.
REQ-016 Illegal select: zero or multiple enables high -> captured result is 0, SEL_ERR=1 for that entry, UNIT_TAG = enables as received.
REQ-017 Storage: two entries -- output register (OREG) and skid register (SREG); each holds {result, tag, err, valid}.
REQ-018 Latency: accept with OREG empty, or OREG draining (OUT_VALID=1 and OUT_READY=1) and SREG empty -> result in OREG, OUT_VALID=1 the next cycle.
REQ-019 Skid: accept while OREG holds an un-drained result (OUT_VALID=1, OUT_READY=0) -> operation captured in SREG.
REQ-020 Drain: OREG drains when OUT_VALID=1 and OUT_READY=1; if SREG valid, SREG moves to OREG in that same edge and SREG empties.
REQ-021 Drain while SREG valid: no accept occurs that cycle because IN_READY=0.
REQ-022 IN_READY: driven by a flop, equal to NOT SREG-valid; never combinationally dependent on OUT_READY or IN_VALID.
REQ-023 States (occupancy): EMPTY (no entries), ONE (OREG only), FULL (OREG+SREG).
REQ-024 Transitions: EMPTY->ONE on accept; ONE->EMPTY on drain without accept; ONE->ONE on drain plus accept, or on neither; ONE->FULL on accept without drain; FULL->ONE on drain; FULL->FULL otherwise.
REQ-025 Ordering: results leave in acceptance order; none dropped or duplicated.
REQ-026 Stability: while OUT_VALID=1 and OUT_READY=0, ALU_OUT, UNIT_TAG and SEL_ERR hold constant.
REQ-027 ERR_CNT: increments by 1 on each accept meeting REQ-016; saturates at 255 and does not wrap.
REQ-028 Invalid-cycle data: when OUT_VALID=0, ALU_OUT holds its last value and is don't-care to downstream.

Reset
REQ-029 RST low -> immediately, independent of CLK: OUT_VALID=0, IN_READY=1, ALU_OUT=0, UNIT_TAG=0, SEL_ERR=0, ERR_CNT=0, both entries invalid, state EMPTY.
REQ-030 Reset mid-operation: any held or skidded result is discarded; no output event follows.
REQ-031 First accept after reset: possible on the first rising edge after RST deasserts.

Verification
REQ-032 Reset, then one op with Arith_Enable=1, Arith_OUT=16'hFFF6 (-10), OUT_READY=1 -> next cycle: OUT_VALID=1, ALU_OUT=16'hFFF6, UNIT_TAG=4'b1000, SEL_ERR=0.
REQ-033 OUT_READY=0; accept CMP op (CMP_OUT=1), then SHIFT op (SHIFT_OUT=16'h0008) -> IN_READY=0 after the second accept; raise OUT_READY -> results 1 then 16'h0008 on consecutive cycles; IN_READY=1 after SREG empties.
REQ-034 Ops with enables 4'b0000, then 4'b0110 -> ALU_OUT=0 with SEL_ERR=1 for each; UNIT_TAG=0000 then 0110; ERR_CNT=2.
REQ-035 300 illegal-select ops with OUT_READY=1 -> ERR_CNT=255 and holds at 255.
REQ-036 In FULL state assert RST low mid-cycle -> OUT_VALID=0 and IN_READY=1 before the next CLK edge; after release, a Logic op (Logic_OUT=16'h00F0) -> ALU_OUT=16'h00F0 with no stale result emitted first.
REQ-037 Random IN_VALID/OUT_READY over 10k cycles against a reference queue model -> order preserved, no loss or duplication, REQ-026 never violated.
